// File: rtl/drive_pkg.sv
// Shared types and default timing constants for the drive start/stop sequencer.
package drive_pkg;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StPwrUp    = 3'd1,
    StIdle     = 3'd2,
    StRun      = 3'd3,
    StStopping = 3'd4,
    StDeadtime = 3'd5,
    StFault    = 3'd6
  } drive_state_e;

  // Action taken when the dead-time after a stop expires.
  typedef enum logic [2:0] {
    PendNone  = 3'd0,
    PendLeft  = 3'd1,
    PendRight = 3'd2,
    PendIdle  = 3'd3,
    PendOff   = 3'd4
  } pend_e;

  localparam int unsigned DefSpeedW   = 10;
  localparam int unsigned DefPwrDly   = 50;
  localparam int unsigned DefDirDly   = 20;
  localparam int unsigned DefRampStep = 8;
  localparam int unsigned TimerW      = 16;

endpackage

// File: rtl/drive_ramp.sv
// Speed ramp register with saturating step toward a target, plus the DAC req/ack feed.
module drive_ramp import drive_pkg::*; #(
  parameter int unsigned SpeedW   = DefSpeedW,
  parameter int unsigned RampStep = DefRampStep
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              ramp_en_i,
  input  logic              clear_i,
  input  logic [SpeedW-1:0] target_i,
  output logic [SpeedW-1:0] cur_o,
  output logic              dac_req_o,
  output logic [SpeedW-1:0] dac_data_o,
  input  logic              dac_ack_i
);

  localparam int unsigned ExtW = SpeedW + 1;

  logic [SpeedW-1:0] cur_q, cur_d;
  logic [SpeedW-1:0] last_q, last_d;
  logic [SpeedW-1:0] data_q, data_d;
  logic              req_q, req_d;

  logic [ExtW-1:0] cur_ext, tgt_ext, step_ext, up_sum, dn_floor;

  // One extra bit so the step can never wrap past either end of the range.
  assign cur_ext  = {1'b0, cur_q};
  assign tgt_ext  = {1'b0, target_i};
  assign step_ext = ExtW'(RampStep);
  assign up_sum   = cur_ext + step_ext;
  assign dn_floor = tgt_ext + step_ext;

  always_comb begin
    cur_d = cur_q;
    if (clear_i) begin
      cur_d = '0;
    end else if (tick_i && ramp_en_i) begin
      if (cur_ext < tgt_ext) begin
        cur_d = (up_sum >= tgt_ext) ? target_i : up_sum[SpeedW-1:0];
      end else if (cur_ext > tgt_ext) begin
        cur_d = (cur_ext >= dn_floor) ? SpeedW'(cur_ext - step_ext) : target_i;
      end
    end
  end

  // A word changed while a request is outstanding goes out on the following request.
  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    last_d = last_q;
    if (req_q) begin
      if (dac_ack_i) begin
        req_d  = 1'b0;
        last_d = data_q;
      end
    end else if (cur_q != last_q) begin
      req_d  = 1'b1;
      data_d = cur_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q  <= '0;
      last_q <= '0;
      data_q <= '0;
      req_q  <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      last_q <= last_d;
      data_q <= data_d;
      req_q  <= req_d;
    end
  end

  assign cur_o      = cur_q;
  assign dac_req_o  = req_q;
  assign dac_data_o = data_q;

endmodule

// File: rtl/drive_sequencer.sv
// Start/stop sequencer for one inverter channel: power-up delay, direction dead-time, ramp.
module drive_sequencer import drive_pkg::*; #(
  parameter int unsigned SPEED_W   = DefSpeedW,
  parameter int unsigned PWR_DLY   = DefPwrDly,
  parameter int unsigned DIR_DLY   = DefDirDly,
  parameter int unsigned RAMP_STEP = DefRampStep
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               f100_in,
  input  logic               cmd_on,
  input  logic               cmd_off,
  input  logic               cmd_stop,
  input  logic               cmd_left,
  input  logic               cmd_right,
  input  logic [SPEED_W-1:0] speed_set,
  input  logic               fault_in,
  output logic               pwr_out,
  output logic               left_out,
  output logic               right_out,
  output logic               on_out,
  output logic               alarm_out,
  output logic [2:0]         state_out,
  output logic               dac_req_out,
  output logic [SPEED_W-1:0] dac_data_out,
  input  logic               dac_ack_in
);

  drive_state_e       state_q, state_d;
  pend_e              pend_q, pend_d;
  logic               dir_right_q, dir_right_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [SPEED_W-1:0] cur;
  logic               dir_cmd, dir_active;
  pend_e              dir_pend;

  // Left and right together cancel each other.
  assign dir_cmd    = cmd_left ^ cmd_right;
  assign dir_pend   = cmd_right ? PendRight : PendLeft;
  assign dir_active = (state_q == StRun) || (state_q == StStopping);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    dir_right_d = dir_right_q;
    timer_d     = timer_q;
    if (f100_in && (timer_q != '0)) timer_d = timer_q - 1'b1;

    unique case (state_q)
      StOff: begin
        if (cmd_on) begin
          state_d = StPwrUp;
          timer_d = TimerW'(PWR_DLY);
        end
      end
      StPwrUp: begin
        if (cmd_off) state_d = StOff;
        else if (timer_q == '0) state_d = StIdle;
      end
      StIdle: begin
        if (cmd_off) begin
          state_d = StOff;
        end else if (dir_cmd) begin
          state_d     = StRun;
          dir_right_d = cmd_right;
        end
      end
      StRun: begin
        if (cmd_off) begin
          pend_d  = PendOff;
          state_d = StStopping;
        end else if (cmd_stop) begin
          pend_d  = PendIdle;
          state_d = StStopping;
        end else if (dir_cmd && (cmd_right != dir_right_q)) begin
          pend_d  = dir_pend;
          state_d = StStopping;
        end
      end
      StStopping: begin
        if (cmd_off) pend_d = PendOff;
        else if (cmd_stop) pend_d = PendIdle;
        else if (dir_cmd) pend_d = dir_pend;
        if (cur == '0) begin
          state_d = StDeadtime;
          timer_d = TimerW'(DIR_DLY);
        end
      end
      StDeadtime: begin
        if (timer_q == '0) begin
          pend_d = PendNone;
          case (pend_q)
            PendLeft:  begin state_d = StRun; dir_right_d = 1'b0; end
            PendRight: begin state_d = StRun; dir_right_d = 1'b1; end
            PendOff:   state_d = StOff;
            default:   state_d = StIdle;
          endcase
        end
      end
      StFault: begin
        if (cmd_off && !fault_in) state_d = StOff;
      end
      default: state_d = StOff;
    endcase

    if (fault_in && (state_q != StOff)) begin
      state_d = StFault;
      pend_d  = PendNone;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StOff;
      pend_q      <= PendNone;
      dir_right_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      dir_right_q <= dir_right_d;
      timer_q     <= timer_d;
    end
  end

  assign pwr_out   = (state_q != StOff) && (state_q != StFault);
  assign left_out  = dir_active && !dir_right_q;
  assign right_out = dir_active && dir_right_q;
  assign on_out    = (state_q == StRun);
  assign alarm_out = (state_q == StFault);
  assign state_out = state_q;

  drive_ramp #(
    .SpeedW   (SPEED_W),
    .RampStep (RAMP_STEP)
  ) u_ramp (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .tick_i     (f100_in),
    .ramp_en_i  (dir_active),
    .clear_i    (state_d == StFault),
    .target_i   ((state_q == StRun) ? speed_set : '0),
    .cur_o      (cur),
    .dac_req_o  (dac_req_out),
    .dac_data_o (dac_data_out),
    .dac_ack_i  (dac_ack_in)
  );

endmodule
